stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N:1 multiplexer for valid/ready streams of W-bit beats, with packet framing.
- Arbitration is fixed-priority or round-robin, locked for the duration of a packet.
- Output is registered: one pipeline stage, full throughput.
- Used wherever several producers share one downstream consumer.

Parameters:
W, 8, data width in bits (>=1)
N, 4, number of input channels (>=2)
RR, 1, 1 = round-robin arbitration, 0 = fixed priority with lowest index winning
SEL_W, $clog2(N), width of the channel index (derived, not overridden)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  N  per-channel beat valid
in_last  input  N  per-channel last beat of packet; sampled only with in_valid
in_data  input  N*W  channel i occupies bits [i*W +: W]
in_ready  output  N  per-channel accept; combinational
out_valid  output  1  registered output beat valid
out_last  output  1  registered last flag
out_data  output  W  registered data
out_sel  output  SEL_W  index of the source channel of the current output beat
out_ready  input  1  downstream accept

Behaviour:
- Reset (rst_n low, asynchronous assert):
  - out_valid=0, out_last=0, out_data=0, out_sel=0.
  - Lock cleared; RR priority pointer=0, so channel 0 has highest priority.
  - Reset mid-packet discards the beat in flight and the lock state.
  - Deassertion takes effect at the first clock edge after it.
- Transfer rules:
  - An output transfer occurs when out_valid && out_ready.
  - An input transfer on channel i occurs when in_valid[i] && in_ready[i].
- Load enable: load = !out_valid || out_ready. The output register accepts a new beat in the same cycle the old one leaves, so one beat per cycle is sustained.
- Grant (combinational):
  - If locked: only the locked channel L is eligible; grant[L] = in_valid[L]. Other channels wait even when valid; if L is idle, a bubble results.
  - If unlocked, RR=1: first valid channel searching from the pointer upward, wrapping N-1 -> 0.
  - If unlocked, RR=0: lowest-index valid channel.
  - in_ready[i] = load && grant[i]. At most one in_ready bit is high per cycle.
  - in_ready may depend on in_valid; producers must not make in_valid depend on in_ready.
- Output register update at the clock edge:
  - If load and a grant exists: out_valid=1, and out_data/out_last/out_sel take the granted channel's data, last flag and index.
  - If load and no grant: out_valid=0; data, last and sel hold their previous values.
  - If !load: all outputs hold.
- Latency: an accepted input beat appears on the output the next cycle. Output remains stable while out_valid && !out_ready.
- Lock:
  - Set to channel g when a beat from g with in_last=0 is accepted.
  - Cleared when a beat from the locked channel with in_last=1 is accepted.
  - A single-beat packet (last=1 on its first beat) never locks.
- RR pointer: updates only when a beat with in_last=1 is accepted from channel g; pointer becomes (g+1) mod N. In RR=0 the pointer is unused.
- Boundary conditions:
  - All channels valid, RR=1: packets are granted in strict rotation.
  - Channel g == N-1 wraps the pointer to 0.
  - With out_ready held low, at most one beat is buffered and all in_ready stay 0 while out_valid=1.
  - out_ready=1 together with a new grant in the same cycle: the old beat leaves and the new beat loads, with no bubble.
  - in_data and in_last on non-granted channels are ignored.

Test Plan:
- Reset: assert rst_n=0 mid-stream with no clock edge -> out_valid=0, out_data=0, out_sel=0 immediately; after release, a beat on ch1 appears with out_sel=1 one cycle after acceptance.
- RR fairness: N=4, all channels continuously valid with single-beat packets (last=1), data=channel index, out_ready=1 -> out_sel sequence 0,1,2,3,0,1… and one beat per cycle after the first.
- Packet lock: ch2 sends 3 beats (last on the 3rd) while ch0 stays valid -> out_sel=2 for 3 consecutive beats, then ch0; in_ready[0]=0 throughout ch2's packet, including a cycle where ch2 drops in_valid (bubble, out_valid=0).
- Fixed priority: RR=0, ch1 and ch3 valid with single-beat packets -> ch1 granted every cycle and ch3 starves; ch3 is granted the cycle after ch1 deasserts.
- Backpressure: out_ready=0 for 5 cycles with ch0 valid data=0xA5 -> output holds 0xA5, all in_ready=0; on out_ready=1 the next beat follows with no gap and no loss or duplication (check with a scoreboard).
- Wrap and width: W=16, N=3, RR=1, ch2 finishes a packet -> next grant searches from ch0; random valid/ready traffic over 10k cycles -> per-channel order preserved, packets never interleaved.

Source files
------------

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N:1 multiplexer for valid/ready streams of W-bit beats with packet framing.
//   The arbiter is either round-robin (RR=1) or fixed priority with the lowest
//   index winning (RR=0). Once the first beat of a multi-beat packet is
//   accepted, the arbiter locks onto that channel until the last beat of the
//   packet is accepted, so packets never interleave on the output.
//   The output is one register stage that can refill in the same cycle it
//   drains, which sustains one beat per cycle.
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel beat valid                         [N]
//   in_last    per-channel last-beat-of-packet flag           [N]
//   in_data    channel i occupies bits [i*W +: W]             [N*W]
//   in_ready   per-channel accept, combinational              [N]
//   out_valid  registered output beat valid
//   out_last   registered last flag
//   out_data   registered beat data                           [W]
//   out_sel    source channel index of the current out beat   [SEL_W]
//   out_ready  downstream accept
module stream_mux_rr #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int RR = 1,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N-1:0]       in_last,
    input  logic [N*W-1:0]     in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic               out_last,
    output logic [W-1:0]       out_data,
    output logic [SEL_W-1:0]   out_sel,
    input  logic               out_ready
);

    logic               out_valid_reg;
    logic               out_last_reg;
    logic [W-1:0]       out_data_reg;
    logic [SEL_W-1:0]   out_sel_reg;

    logic               locked_reg;
    logic [SEL_W-1:0]   lock_ch_reg;
    logic [SEL_W-1:0]   ptr_reg;

    logic               load;
    logic               grant_any;
    logic [SEL_W-1:0]   grant_idx;
    logic [SEL_W-1:0]   cand;

    // (base + k) mod N without a divider; k is always below N
    function automatic logic [SEL_W-1:0] rot(input logic [SEL_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) begin
            s = s - N;
        end
        return SEL_W'(s);
    endfunction

    // The output register can take a new beat whenever it is empty or its
    // current beat is leaving this cycle.
    assign load = !out_valid_reg || out_ready;

    // Grant search. The loop runs from the lowest priority candidate to the
    // highest so that the last hit (the highest priority one) wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (locked_reg) begin
            grant_any = in_valid[lock_ch_reg];
            grant_idx = lock_ch_reg;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                cand = (RR != 0) ? rot(ptr_reg, k) : SEL_W'(k);
                if (in_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_ready
        assign in_ready[gi] = load && grant_any && (grant_idx == SEL_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
            locked_reg    <= 1'b0;
            lock_ch_reg   <= '0;
            ptr_reg       <= '0;
        end else if (load) begin
            if (grant_any) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= in_data[int'(grant_idx) * W +: W];
                out_last_reg  <= in_last[grant_idx];
                out_sel_reg   <= grant_idx;
                if (in_last[grant_idx]) begin
                    // End of packet (or single-beat packet): release the lock
                    // and hand top priority to the next channel up.
                    locked_reg <= 1'b0;
                    ptr_reg    <= (grant_idx == SEL_W'(N - 1)) ? '0 : grant_idx + SEL_W'(1);
                end else begin
                    locked_reg  <= 1'b1;
                    lock_ch_reg <= grant_idx;
                end
            end else begin
                // Bubble: data, last and sel keep their previous values.
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_data  = out_data_reg;
    assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr. Three instances share clock and reset:
//   dut 0: W=8,  N=4, round-robin
//   dut 1: W=8,  N=4, fixed priority
//   dut 2: W=16, N=3, round-robin
// A behavioural model per instance is compared every cycle, a per-channel
// scoreboard tracks beat order and packet integrity, and directed phases
// pin exact values.
module tb_stream_mux_rr;

    localparam int NCH [3] = '{4, 4, 3};
    localparam int RRM [3] = '{1, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [3:0]  iv   [3];
    logic [3:0]  il   [3];
    logic [15:0] id   [3][4];
    logic        ordy [3];

    logic [3:0]  ir   [3];
    logic        ov   [3];
    logic        ol   [3];
    logic [15:0] od   [3];
    logic [1:0]  os   [3];

    wire [7:0] od0;
    wire [7:0] od1;
    wire [2:0] ir2;

    assign od[0] = {8'h00, od0};
    assign od[1] = {8'h00, od1};
    assign ir[2] = {1'b0, ir2};

    stream_mux_rr #(.W(8), .N(4), .RR(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_last(il[0]),
        .in_data({id[0][3][7:0], id[0][2][7:0], id[0][1][7:0], id[0][0][7:0]}),
        .in_ready(ir[0]),
        .out_valid(ov[0]), .out_last(ol[0]), .out_data(od0), .out_sel(os[0]),
        .out_ready(ordy[0])
    );

    stream_mux_rr #(.W(8), .N(4), .RR(0)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_last(il[1]),
        .in_data({id[1][3][7:0], id[1][2][7:0], id[1][1][7:0], id[1][0][7:0]}),
        .in_ready(ir[1]),
        .out_valid(ov[1]), .out_last(ol[1]), .out_data(od1), .out_sel(os[1]),
        .out_ready(ordy[1])
    );

    stream_mux_rr #(.W(16), .N(3), .RR(1)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[2][2:0]), .in_last(il[2][2:0]),
        .in_data({id[2][2], id[2][1], id[2][0]}),
        .in_ready(ir2),
        .out_valid(ov[2]), .out_last(ol[2]), .out_data(od[2]), .out_sel(os[2]),
        .out_ready(ordy[2])
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit trace    = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [15:0] dmask(input int d, input logic [15:0] x);
        return (d < 2) ? {8'h00, x[7:0]} : x;
    endfunction

    // ---------------- behavioural model ----------------
    logic        m_ov   [3];
    logic        m_ol   [3];
    logic [15:0] m_od   [3];
    int          m_os   [3];
    bit          m_lock [3];
    int          m_lch  [3];
    int          m_ptr  [3];

    task automatic m_reset(input int d);
        m_ov[d] = 1'b0; m_ol[d] = 1'b0; m_od[d] = '0; m_os[d] = 0;
        m_lock[d] = 1'b0; m_lch[d] = 0; m_ptr[d] = 0;
    endtask

    // channel that wins this cycle, -1 if none
    function automatic int m_grant(input int d);
        int c;
        if (m_lock[d]) return iv[d][m_lch[d]] ? m_lch[d] : -1;
        for (int k = 0; k < NCH[d]; k++) begin
            c = (RRM[d] != 0) ? (m_ptr[d] + k) % NCH[d] : k;
            if (iv[d][c]) return c;
        end
        return -1;
    endfunction

    task automatic m_step(input int d);
        int g;
        g = m_grant(d);
        if (!m_ov[d] || ordy[d]) begin
            if (g >= 0) begin
                m_ov[d] = 1'b1;
                m_od[d] = dmask(d, id[d][g]);
                m_ol[d] = il[d][g];
                m_os[d] = g;
                if (il[d][g]) begin
                    m_lock[d] = 1'b0;
                    m_ptr[d]  = (g + 1) % NCH[d];
                end else begin
                    m_lock[d] = 1'b1;
                    m_lch[d]  = g;
                end
            end else begin
                m_ov[d] = 1'b0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [16:0] sbq [12][$];
    bit          pkt_open [3];
    int          pkt_ch   [3];

    // ---------------- compare process ----------------
    initial begin
        int g;
        int q;
        logic [3:0] er;
        logic [16:0] e;
        for (int d = 0; d < 3; d++) begin
            m_reset(d);
            pkt_open[d] = 1'b0;
            pkt_ch[d] = 0;
        end
        forever begin
            @(negedge clk);
            #3;
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) begin
                    m_reset(d);
                    pkt_open[d] = 1'b0;
                    for (int c = 0; c < 4; c++) sbq[d*4+c].delete();
                end
                g  = m_grant(d);
                er = '0;
                if ((!m_ov[d] || ordy[d]) && g >= 0) er[g] = 1'b1;
                chk($sformatf("d%0d_in_ready", d), 32'(ir[d]), 32'(er));
                chk($sformatf("d%0d_out_valid", d), 32'(ov[d]), 32'(m_ov[d]));
                chk($sformatf("d%0d_out_last", d), 32'(ol[d]), 32'(m_ol[d]));
                chk($sformatf("d%0d_out_data", d), 32'(od[d]), 32'(m_od[d]));
                chk($sformatf("d%0d_out_sel", d), 32'(os[d]), 32'(m_os[d]));
                if (rst_n) begin
                    if (ov[d] && ordy[d]) begin
                        q = d * 4 + int'(os[d]);
                        if (trace) $display("dut%0d out beat ch%0d data 0x%0h last %0d", d, os[d], od[d], ol[d]);
                        chk($sformatf("d%0d_sb_has_beat", d), 32'(sbq[q].size() > 0), 32'd1);
                        if (sbq[q].size() > 0) begin
                            e = sbq[q].pop_front();
                            chk($sformatf("d%0d_sb_beat", d), 32'({ol[d], od[d]}), 32'(e));
                        end
                        if (pkt_open[d]) chk($sformatf("d%0d_no_interleave", d), 32'(os[d]), 32'(pkt_ch[d]));
                        pkt_open[d] = !ol[d];
                        pkt_ch[d]   = int'(os[d]);
                    end
                    for (int c = 0; c < NCH[d]; c++) begin
                        if (iv[d][c] && ir[d][c]) sbq[d*4+c].push_back({il[d][c], dmask(d, id[d][c])});
                    end
                end
            end
            @(posedge clk);
            for (int d = 0; d < 3; d++) begin
                if (!rst_n) m_reset(d);
                else m_step(d);
            end
        end
    end

    // ---------------- stimulus ----------------
    int seq [3][4];

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = '0; il[d] = '0; ordy[d] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                id[d][c] = '0;
                seq[d][c] = 0;
            end
        end
        repeat (2) @(negedge clk);
        #2;
        for (int d = 0; d < 3; d++) begin
            chk("rst_out_valid", 32'(ov[d]), 32'd0);
            chk("rst_out_data", 32'(od[d]), 32'd0);
            chk("rst_out_sel", 32'(os[d]), 32'd0);
            chk("rst_out_last", 32'(ol[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin rotation, single-beat packets, all channels valid
        @(negedge clk);
        iv[0] = 4'hF; il[0] = 4'hF;
        for (int c = 0; c < 4; c++) id[0][c] = 16'(c);
        #2 chk("A_ready_first", 32'(ir[0]), 32'b0001);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            #2;
            chk("A_sel", 32'(os[0]), 32'((k - 1) % 4));
            chk("A_valid", 32'(ov[0]), 32'd1);
            chk("A_data", 32'(od[0]), 32'((k - 1) % 4));
            chk("A_ready", 32'(ir[0]), 32'(4'b0001 << (k % 4)));
        end
        @(negedge clk); iv[0] = '0;
        @(negedge clk);

        // Packet lock on ch2 with ch0 waiting, including a bubble
        @(negedge clk);
        iv[0] = 4'b0100; il[0] = 4'b0000; id[0][2] = 16'h21;
        #2 chk("B_ready_c0", 32'(ir[0]), 32'b0100);
        @(negedge clk);
        iv[0] = 4'b0101; il[0] = 4'b0001; id[0][2] = 16'h22; id[0][0] = 16'h10;
        #2 chk("B_ready_c1", 32'(ir[0]), 32'b0100);
        chk("B_sel_c1", 32'(os[0]), 32'd2);
        chk("B_data_c1", 32'(od[0]), 32'h21);
        @(negedge clk);
        iv[0] = 4'b0001;
        #2 chk("B_ready_c2", 32'(ir[0]), 32'b0000);
        chk("B_data_c2", 32'(od[0]), 32'h22);
        @(negedge clk);
        iv[0] = 4'b0101; il[0] = 4'b0101; id[0][2] = 16'h23;
        #2 chk("B_ready_c3", 32'(ir[0]), 32'b0100);
        chk("B_bubble", 32'(ov[0]), 32'd0);
        @(negedge clk);
        iv[0] = 4'b0001;
        #2 chk("B_ready_c4", 32'(ir[0]), 32'b0001);
        chk("B_data_c4", 32'(od[0]), 32'h23);
        chk("B_last_c4", 32'(ol[0]), 32'd1);
        @(negedge clk);
        iv[0] = '0;
        #2 chk("B_sel_c5", 32'(os[0]), 32'd0);
        chk("B_data_c5", 32'(od[0]), 32'h10);
        @(negedge clk);
        #2 chk("B_idle", 32'(ov[0]), 32'd0);

        // Fixed priority: ch1 starves ch3
        @(negedge clk);
        iv[1] = 4'b1010; il[1] = 4'hF; id[1][1] = 16'h11; id[1][3] = 16'h33;
        #2 chk("C_ready_c0", 32'(ir[1]), 32'b0010);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2 chk("C_sel", 32'(os[1]), 32'd1);
            chk("C_ready", 32'(ir[1]), 32'b0010);
        end
        @(negedge clk);
        iv[1] = 4'b1000;
        #2 chk("C_ready_ch3", 32'(ir[1]), 32'b1000);
        @(negedge clk);
        iv[1] = '0;
        #2 chk("C_sel_ch3", 32'(os[1]), 32'd3);
        chk("C_data_ch3", 32'(od[1]), 32'h33);
        @(negedge clk);

        // Backpressure on dut0
        @(negedge clk);
        iv[0] = 4'b0001; il[0] = 4'b0001; id[0][0] = 16'hA5;
        #2 chk("D_ready_load", 32'(ir[0]), 32'b0001);
        @(negedge clk);
        id[0][0] = 16'hA6; ordy[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #2 chk("D_hold_data", 32'(od[0]), 32'hA5);
            chk("D_hold_valid", 32'(ov[0]), 32'd1);
            chk("D_hold_ready", 32'(ir[0]), 32'b0000);
            @(negedge clk);
        end
        ordy[0] = 1'b1;
        #2 chk("D_release_ready", 32'(ir[0]), 32'b0001);
        chk("D_release_data", 32'(od[0]), 32'hA5);
        @(negedge clk);
        iv[0] = '0;
        #2 chk("D_next_data", 32'(od[0]), 32'hA6);
        chk("D_next_valid", 32'(ov[0]), 32'd1);
        @(negedge clk);
        #2 chk("D_drained", 32'(ov[0]), 32'd0);

        // Asynchronous reset mid-packet on dut0 (locked on ch0)
        @(negedge clk);
        iv[0] = 4'b0001; il[0] = 4'b0000; id[0][0] = 16'h5A;
        #2 chk("E_ready_pre", 32'(ir[0]), 32'b0001);
        @(negedge clk);
        iv[0] = '0;
        #1 rst_n = 1'b0;
        #1 chk("E_rst_valid", 32'(ov[0]), 32'd0);
        chk("E_rst_data", 32'(od[0]), 32'd0);
        chk("E_rst_sel", 32'(os[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        iv[0] = 4'b0010; il[0] = 4'b0010; id[0][1] = 16'h77;
        #2 chk("E_ready_ch1", 32'(ir[0]), 32'b0010);
        @(negedge clk);
        iv[0] = '0;
        #2 chk("E_sel_ch1", 32'(os[0]), 32'd1);
        chk("E_data_ch1", 32'(od[0]), 32'h77);
        chk("E_valid_ch1", 32'(ov[0]), 32'd1);
        @(negedge clk);

        // dut2: pointer wrap after ch2 finishes
        @(negedge clk);
        iv[2] = 4'b0100; il[2] = 4'b0111; id[2][2] = 16'hC2C2;
        #2 chk("F_ready_ch2", 32'(ir[2]), 32'b0100);
        @(negedge clk);
        iv[2] = 4'b0111; id[2][0] = 16'hC0C0; id[2][1] = 16'hC1C1;
        #2 chk("F_ready_wrap", 32'(ir[2]), 32'b0001);
        chk("F_data_ch2", 32'(od[2]), 32'hC2C2);
        @(negedge clk);
        #2 chk("F_ready_next", 32'(ir[2]), 32'b0010);
        chk("F_data_ch0", 32'(od[2]), 32'hC0C0);
        @(negedge clk);
        iv[2] = '0;
        #2 chk("F_data_ch1", 32'(od[2]), 32'hC1C1);
        @(negedge clk);

        // Random traffic on all instances
        trace = 1'b0;
        for (int t = 0; t < 10000; t++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                ordy[d] = ($urandom_range(0, 9) < 7);
                for (int c = 0; c < NCH[d]; c++) begin
                    iv[d][c] = ($urandom_range(0, 3) != 0);
                    il[d][c] = ($urandom_range(0, 2) == 0);
                    id[d][c] = 16'(seq[d][c] * 4 + c);
                end
            end
            #2;
            for (int d = 0; d < 3; d++)
                for (int c = 0; c < NCH[d]; c++)
                    if (iv[d][c] && ir[d][c]) seq[d][c]++;
        end
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            iv[d] = '0;
            ordy[d] = 1'b1;
        end
        repeat (4) @(negedge clk);
        #4;
        for (int q = 0; q < 12; q++) chk("G_sb_drained", 32'(sbq[q].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
